// File: rtl/lookupflow_req.sv
// lookupflow_req: ingress-side OpenFlow lookup initiator.
// Parses Ethernet/IPv4 headers from the RX byte stream, builds the 116-bit key,
// issues one lookup request pulse per frame, waits for ack/err/timeout and presents
// the forwarding decision through a valid/ready result interface.
module lookupflow_req #(
    parameter logic [3:0]  PORT_NUM = 4'h0,
    parameter logic [15:0] TIMEOUT  = 16'd64
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    input  logic         rx_sof,
    input  logic         rx_valid,
    input  logic [7:0]   rx_data,
    input  logic         rx_eof,
    output logic         of_lookup_req,
    output logic [115:0] of_lookup_data,
    input  logic         of_lookup_ack,
    input  logic         of_lookup_err,
    input  logic [3:0]   of_lookup_fwd_port,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [3:0]   res_fwd_port,
    output logic         res_err,
    output logic [15:0]  drop_cnt
);

    typedef enum logic [2:0] {IDLE, PARSE, REQ, WAIT, DONE} state_t;

    state_t      state;
    logic [5:0]  byte_cnt;   // index of the next byte to arrive in PARSE
    logic [15:0] tmo_cnt;    // cycles elapsed since the request pulse

    logic [47:0] src_mac;
    logic [7:0]  etype_hi;
    logic [31:0] src_ip;
    logic [23:0] dst_ip_hi;

    logic sof_beat;
    logic data_beat;
    logic etype_bad;

    assign sof_beat  = rx_valid & rx_sof;
    assign data_beat = (state == PARSE) & rx_valid & ~rx_sof;
    assign etype_bad = ({etype_hi, rx_data} != 16'h0800);

    // Header field capture; bytes arrive MSB first so each field is shifted in.
    always_ff @(posedge sys_clk) begin
        if (data_beat) begin
            if (byte_cnt >= 6'd6 && byte_cnt <= 6'd11)
                src_mac <= {src_mac[39:0], rx_data};
            if (byte_cnt == 6'd12)
                etype_hi <= rx_data;
            if (byte_cnt >= 6'd26 && byte_cnt <= 6'd29)
                src_ip <= {src_ip[23:0], rx_data};
            if (byte_cnt >= 6'd30 && byte_cnt <= 6'd32)
                dst_ip_hi <= {dst_ip_hi[15:0], rx_data};
        end
    end

    // Frame-level FSM: parse, request, wait for ack/timeout, hold result until accepted.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state          <= IDLE;
            byte_cnt       <= 6'd0;
            tmo_cnt        <= 16'd0;
            of_lookup_req  <= 1'b0;
            of_lookup_data <= '0;
            res_valid      <= 1'b0;
            res_fwd_port   <= 4'h0;
            res_err        <= 1'b0;
            drop_cnt       <= 16'd0;
        end else begin
            of_lookup_req <= 1'b0;

            // A new frame can only be taken from IDLE; anything else is counted and ignored.
            if (sof_beat && state != IDLE && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;

            case (state)
                IDLE: begin
                    if (sof_beat) begin
                        byte_cnt <= 6'd1;
                        if (rx_eof) begin
                            state        <= DONE;
                            res_valid    <= 1'b1;
                            res_err      <= 1'b1;
                            res_fwd_port <= 4'h0;
                        end else begin
                            state <= PARSE;
                        end
                    end
                end
                PARSE: begin
                    if (data_beat) begin
                        if (byte_cnt != 6'd63)
                            byte_cnt <= byte_cnt + 6'd1;
                        if ((byte_cnt == 6'd13 && etype_bad) ||
                            (byte_cnt != 6'd33 && rx_eof)) begin
                            state        <= DONE;
                            res_valid    <= 1'b1;
                            res_err      <= 1'b1;
                            res_fwd_port <= 4'h0;
                        end else if (byte_cnt == 6'd33) begin
                            state          <= REQ;
                            of_lookup_req  <= 1'b1;
                            of_lookup_data <= {PORT_NUM, src_mac, src_ip, dst_ip_hi, rx_data};
                        end
                    end
                end
                REQ: begin
                    state   <= WAIT;
                    tmo_cnt <= 16'd1;
                end
                WAIT: begin
                    // Ack takes priority over a timeout expiring in the same cycle.
                    if (of_lookup_ack) begin
                        state        <= DONE;
                        res_valid    <= 1'b1;
                        res_fwd_port <= of_lookup_fwd_port;
                        res_err      <= of_lookup_err;
                    end else if (tmo_cnt == TIMEOUT - 16'd1) begin
                        state        <= DONE;
                        res_valid    <= 1'b1;
                        res_fwd_port <= 4'h0;
                        res_err      <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lookupflow_req.sv
// Testbench for lookupflow_req: table of whole-frame vectors plus hand-written
// sequences for timeout, ack/timeout collision, busy drops and reset abort.
module tb_lookupflow_req;

    localparam logic [47:0]  SMAC    = 48'h406c8f37f1f8;
    localparam logic [31:0]  SIP     = 32'h0A0000C8;
    localparam logic [31:0]  DIP     = 32'h0A000002;
    localparam logic [115:0] EXP_KEY = 116'h1_406c8f37f1f8_0A0000C8_0A000002;

    logic         sys_clk;
    logic         sys_rst;
    logic         rx_sof;
    logic         rx_valid;
    logic [7:0]   rx_data;
    logic         rx_eof;
    logic         of_lookup_req;
    logic [115:0] of_lookup_data;
    logic         of_lookup_ack;
    logic         of_lookup_err;
    logic [3:0]   of_lookup_fwd_port;
    logic         res_valid;
    logic         res_ready;
    logic [3:0]   res_fwd_port;
    logic         res_err;
    logic [15:0]  drop_cnt;

    lookupflow_req #(.PORT_NUM(4'h1), .TIMEOUT(16'd64)) dut (
        .sys_clk            (sys_clk),
        .sys_rst            (sys_rst),
        .rx_sof             (rx_sof),
        .rx_valid           (rx_valid),
        .rx_data            (rx_data),
        .rx_eof             (rx_eof),
        .of_lookup_req      (of_lookup_req),
        .of_lookup_data     (of_lookup_data),
        .of_lookup_ack      (of_lookup_ack),
        .of_lookup_err      (of_lookup_err),
        .of_lookup_fwd_port (of_lookup_fwd_port),
        .res_valid          (res_valid),
        .res_ready          (res_ready),
        .res_fwd_port       (res_fwd_port),
        .res_err            (res_err),
        .drop_cnt           (drop_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int req_cnt = 0;
    int last_req_cyc = 0;

    // Cycle counter and request pulse monitor
    always @(posedge sys_clk) begin
        cyc <= cyc + 1;
        if (of_lookup_req) begin
            req_cnt      <= req_cnt + 1;
            last_req_cyc <= cyc;
        end
    end

    typedef struct {
        logic [15:0] etype;
        int          len;
        bit          do_ack;
        logic        ack_err;
        logic [3:0]  ack_fwd;
        int          exp_reqs;
        logic [3:0]  exp_fwd;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    int           sof_cyc;
    bit           res_seen;
    int           res_cyc;
    bit           req_seen;
    logic [115:0] key_got;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] fb(input int i, input logic [15:0] et);
        logic [47:0] m;
        logic [31:0] s;
        logic [31:0] d;
        m = SMAC;
        s = SIP;
        d = DIP;
        if (i < 6)       return 8'h02 + 8'(i);
        else if (i < 12) return m[47 - 8*(i-6) -: 8];
        else if (i == 12) return et[15:8];
        else if (i == 13) return et[7:0];
        else if (i >= 26 && i < 30) return s[31 - 8*(i-26) -: 8];
        else if (i >= 30 && i < 34) return d[31 - 8*(i-30) -: 8];
        else return 8'(i) ^ 8'h5A;
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send_frame(input logic [15:0] et, input int len);
        for (int i = 0; i < len; i++) begin
            tick();
            rx_valid = 1'b1;
            rx_sof   = (i == 0);
            rx_eof   = (i == len - 1);
            rx_data  = fb(i, et);
            if (i == 0) sof_cyc = cyc;
        end
        tick();
        rx_valid = 1'b0;
        rx_sof   = 1'b0;
        rx_eof   = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic responder(input bit do_ack, input logic err, input logic [3:0] fwd);
        req_seen = 1'b0;
        if (do_ack) begin
            for (int k = 0; k < 100; k++) begin
                tick();
                if (of_lookup_req) begin
                    req_seen = 1'b1;
                    key_got  = of_lookup_data;
                    break;
                end
            end
            if (req_seen) begin
                tick();
                of_lookup_ack      = 1'b1;
                of_lookup_err      = err;
                of_lookup_fwd_port = fwd;
                tick();
                of_lookup_ack      = 1'b0;
                of_lookup_err      = 1'b0;
                of_lookup_fwd_port = 4'h0;
            end
        end
    endtask

    task automatic wait_result();
        res_seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (res_valid) begin
                res_seen = 1'b1;
                res_cyc  = cyc;
                break;
            end
        end
    endtask

    task automatic accept_result(input string name);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({name, "_valid_cleared"}, 128'(res_valid), 128'(0));
    endtask

    int req_base;
    int r0;

    initial begin
        vecs[0] = '{16'h0800, 60, 1'b1, 1'b0, 4'hE, 1, 4'hE, 1'b0, 36};
        vecs[1] = '{16'h0806, 60, 1'b0, 1'b0, 4'h0, 0, 4'h0, 1'b1, 14};
        vecs[2] = '{16'h0800, 30, 1'b0, 1'b0, 4'h0, 0, 4'h0, 1'b1, 30};
        vecs[3] = '{16'h0800, 34, 1'b1, 1'b1, 4'h3, 1, 4'h3, 1'b1, 36};
        vecs[4] = '{16'h0800, 64, 1'b1, 1'b0, 4'h5, 1, 4'h5, 1'b0, 36};
        vecs[5] = '{16'h86DD, 14, 1'b0, 1'b0, 4'h0, 0, 4'h0, 1'b1, 14};
        vecs[6] = '{16'h0800, 33, 1'b0, 1'b0, 4'h0, 0, 4'h0, 1'b1, 33};

        sys_rst = 1'b1;
        rx_sof = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rx_eof = 1'b0;
        of_lookup_ack = 1'b0; of_lookup_err = 1'b0; of_lookup_fwd_port = 4'h0;
        res_ready = 1'b0;
        repeat (3) tick();
        sys_rst = 1'b0;
        tick();

        chk("rst_req",   128'(of_lookup_req),  128'(0));
        chk("rst_data",  128'(of_lookup_data), 128'(0));
        chk("rst_valid", 128'(res_valid),      128'(0));
        chk("rst_fwd",   128'(res_fwd_port),   128'(0));
        chk("rst_err",   128'(res_err),        128'(0));
        chk("rst_drop",  128'(drop_cnt),       128'(0));

        // Table-driven whole-frame vectors
        for (int v = 0; v < 7; v++) begin
            req_base = req_cnt;
            key_got  = '0;
            fork
                send_frame(vecs[v].etype, vecs[v].len);
                responder(vecs[v].do_ack, vecs[v].ack_err, vecs[v].ack_fwd);
                wait_result();
            join
            chk($sformatf("v%0d_res_seen", v), 128'(res_seen), 128'(1));
            chk($sformatf("v%0d_latency", v), 128'(res_cyc - sof_cyc), 128'(vecs[v].exp_lat));
            chk($sformatf("v%0d_valid_held", v), 128'(res_valid), 128'(1));
            chk($sformatf("v%0d_fwd", v), 128'(res_fwd_port), 128'(vecs[v].exp_fwd));
            chk($sformatf("v%0d_err", v), 128'(res_err), 128'(vecs[v].exp_err));
            chk($sformatf("v%0d_reqs", v), 128'(req_cnt - req_base), 128'(vecs[v].exp_reqs));
            if (vecs[v].exp_reqs != 0)
                chk($sformatf("v%0d_key", v), 128'(key_got), 128'(EXP_KEY));
            accept_result($sformatf("v%0d", v));
            repeat (3) tick();
        end
        chk("drop_after_vectors", 128'(drop_cnt), 128'(0));

        // Timeout: no ack, result exactly 64 cycles after the request; late ack ignored
        req_base = req_cnt;
        fork
            send_frame(16'h0800, 34);
            wait_result();
        join
        chk("tmo_seen", 128'(res_seen), 128'(1));
        chk("tmo_delay", 128'(res_cyc - last_req_cyc), 128'(64));
        chk("tmo_err", 128'(res_err), 128'(1));
        chk("tmo_fwd", 128'(res_fwd_port), 128'(0));
        of_lookup_ack = 1'b1; of_lookup_fwd_port = 4'hF; of_lookup_err = 1'b0;
        tick();
        of_lookup_ack = 1'b0; of_lookup_fwd_port = 4'h0;
        chk("tmo_late_ack_err", 128'(res_err), 128'(1));
        chk("tmo_late_ack_fwd", 128'(res_fwd_port), 128'(0));
        accept_result("tmo");
        of_lookup_ack = 1'b1; of_lookup_fwd_port = 4'hF;
        tick();
        of_lookup_ack = 1'b0; of_lookup_fwd_port = 4'h0;
        repeat (5) tick();
        chk("tmo_no_second_result", 128'(res_valid), 128'(0));
        chk("tmo_reqs", 128'(req_cnt - req_base), 128'(1));

        // Ack arriving on the final timeout cycle wins
        send_frame(16'h0800, 34);
        chk("race_req_pulse", 128'(of_lookup_req), 128'(1));
        r0 = cyc;
        repeat (63) tick();
        chk("race_not_yet", 128'(res_valid), 128'(0));
        of_lookup_ack = 1'b1; of_lookup_err = 1'b0; of_lookup_fwd_port = 4'h7;
        tick();
        of_lookup_ack = 1'b0; of_lookup_fwd_port = 4'h0;
        chk("race_cycle", 128'(cyc - r0), 128'(64));
        chk("race_valid", 128'(res_valid), 128'(1));
        chk("race_err", 128'(res_err), 128'(0));
        chk("race_fwd", 128'(res_fwd_port), 128'(7));
        accept_result("race");

        // Busy drops: result held while three frames start, then accept with sof same cycle
        send_frame(16'h86DD, 14);
        chk("busy_valid", 128'(res_valid), 128'(1));
        req_base = req_cnt;
        for (int f = 0; f < 3; f++) begin
            rx_valid = 1'b1; rx_sof = 1'b1; rx_eof = 1'b0; rx_data = 8'hAA;
            tick();
            rx_sof = 1'b0; rx_eof = 1'b1;
            tick();
            rx_valid = 1'b0; rx_eof = 1'b0;
            tick();
            chk($sformatf("busy_hold_%0d", f), 128'({res_valid, res_err, res_fwd_port}), 128'(6'b110000));
        end
        tick();
        chk("busy_drop3", 128'(drop_cnt), 128'(3));
        res_ready = 1'b1;
        rx_valid = 1'b1; rx_sof = 1'b1; rx_eof = 1'b0; rx_data = 8'hAA;
        tick();
        res_ready = 1'b0; rx_sof = 1'b0;
        for (int i = 1; i < 40; i++) begin
            rx_data = fb(i, 16'h0800);
            rx_eof  = (i == 39);
            tick();
        end
        rx_valid = 1'b0; rx_eof = 1'b0;
        chk("busy_drop4", 128'(drop_cnt), 128'(4));
        repeat (5) tick();
        chk("busy_no_result", 128'(res_valid), 128'(0));
        chk("busy_no_req", 128'(req_cnt - req_base), 128'(0));

        // Reset while waiting for ack aborts at once; the later ack is stale
        send_frame(16'h0800, 34);
        repeat (3) tick();
        chk("wait_key_held", 128'(of_lookup_data), 128'(EXP_KEY));
        sys_rst = 1'b1;
        #1;
        chk("arst_data", 128'(of_lookup_data), 128'(0));
        chk("arst_drop", 128'(drop_cnt), 128'(0));
        chk("arst_outs", 128'({of_lookup_req, res_valid, res_err, res_fwd_port}), 128'(0));
        tick();
        sys_rst = 1'b0;
        of_lookup_ack = 1'b1; of_lookup_fwd_port = 4'h9;
        tick();
        of_lookup_ack = 1'b0; of_lookup_fwd_port = 4'h0;
        repeat (10) tick();
        chk("arst_stale_ack", 128'(res_valid), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
